// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, states, op classes,
// ALU ops, PC source and error codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_ADD, CL_SUB, CL_ORI, CL_LUI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_ILLEGAL
  } op_class_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_OR = 2'b01, ALU_SUB = 2'b10, ALU_LUI = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_IMEM_TO = 2'b10, ERR_DMEM_TO = 2'b11
  } err_t;

  function automatic alu_op_t class_alu_op(input op_class_t c);
    case (c)
      CL_ORI:         return ALU_OR;
      CL_LUI:         return ALU_LUI;
      CL_SUB, CL_BEQ: return ALU_SUB;
      default:        return ALU_ADD;
    endcase
  endfunction

  function automatic logic class_uses_imm(input op_class_t c);
    return (c == CL_ORI) || (c == CL_LUI) || (c == CL_LW) || (c == CL_SW);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory handshakes and the fetched instruction word.
interface multicycle_sequencer_if;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_ready;
  logic [31:0] instruction;

  modport master (output imem_req, dmem_req, input imem_ready, dmem_ready, instruction);
  modport slave  (input imem_req, dmem_req, output imem_ready, dmem_ready, instruction);
endinterface

// File: rtl/mips_op_decode.sv
// Combinational opcode/funct to instruction-class decode.
module mips_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CL_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD)      op_class = CL_ADD;
        else if (funct == FN_SUB) op_class = CL_SUB;
      end
      OP_J:    op_class = CL_J;
      OP_BEQ:  op_class = CL_BEQ;
      OP_ORI:  op_class = CL_ORI;
      OP_LUI:  op_class = CL_LUI;
      OP_LW:   op_class = CL_LW;
      OP_SW:   op_class = CL_SW;
      default: op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the MIPS core: fetch/decode/exec/mem/wb sequencing,
// memory wait timeouts, sticky trap and retired-instruction count.
//
// state  | meaning
// IDLE   | halted, waiting for run
// FETCH  | imem_req until imem_ready; loads IR and PC+4
// DECODE | classify instruction; j retires here, illegal traps
// EXEC   | ALU controls driven; beq retires here
// MEM    | dmem_req until dmem_ready; sw retires here
// WB     | one-cycle register file write; retire
// TRAP   | sticky error, left only by reset
module multicycle_sequencer
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int RET_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n_sequencer,
  input  logic                 run,
  multicycle_sequencer_if.master bus,
  input  logic                 zero,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 ctrl_regFile_write,
  output logic                 select_regWritten,
  output logic                 ctrl_dataMem_Write,
  output logic                 ctrl_dataMem2reg,
  output logic                 select_anotherAluSource,
  output logic [1:0]           select_aluPerformance,
  output logic                 halted,
  output logic [1:0]           err_code,
  output logic [RET_W-1:0]     retired_count
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t          state, state_nxt;
  op_class_t       dec_class, class_q;
  logic [1:0]      err_q, err_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic            retire;
  logic            waiting;
  logic            timeout_hit;
  logic            unused_bits;

  mips_op_decode u_decode (
    .opcode   (bus.instruction[31:26]),
    .funct    (bus.instruction[5:0]),
    .op_class (dec_class)
  );

  assign unused_bits = ^bus.instruction[25:6];
  assign waiting     = ((state == ST_FETCH) && !bus.imem_ready) ||
                       ((state == ST_MEM)   && !bus.dmem_ready);
  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign err_code    = err_q;

  always_ff @(posedge clk or negedge rst_n_sequencer) begin
    if (!rst_n_sequencer) begin
      state         <= ST_IDLE;
      class_q       <= CL_ILLEGAL;
      err_q         <= ERR_NONE;
      wait_cnt      <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (state == ST_DECODE) class_q <= dec_class;
      // MEM can follow MEM->FETCH directly (sw retire), so clear on any state change
      if (state_nxt != state) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_cnt + CNT_W'(1);
      if (retire) retired_count <= retired_count + RET_W'(1);
    end
  end

  always_comb begin
    state_nxt               = state;
    err_nxt                 = err_q;
    retire                  = 1'b0;
    halted                  = 1'b0;
    bus.imem_req            = 1'b0;
    bus.dmem_req            = 1'b0;
    ir_load                 = 1'b0;
    pc_write                = 1'b0;
    pc_src                  = PC_SEQ;
    ctrl_regFile_write      = 1'b0;
    select_regWritten       = 1'b0;
    ctrl_dataMem_Write      = 1'b0;
    ctrl_dataMem2reg        = 1'b0;
    select_anotherAluSource = 1'b0;
    select_aluPerformance   = ALU_ADD;

    if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      select_anotherAluSource = class_uses_imm(class_q);
      select_aluPerformance   = class_alu_op(class_q);
    end

    case (state)
      ST_IDLE: begin
        halted = 1'b1;
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_load   = 1'b1;
          pc_write  = 1'b1;
          state_nxt = ST_DECODE;
        end else if (timeout_hit) begin
          state_nxt = ST_TRAP;
          err_nxt   = ERR_IMEM_TO;
        end
      end
      ST_DECODE: begin
        case (dec_class)
          CL_ILLEGAL: begin
            state_nxt = ST_TRAP;
            err_nxt   = ERR_ILLEGAL;
          end
          CL_J: begin
            pc_write  = 1'b1;
            pc_src    = PC_JUMP;
            retire    = 1'b1;
            state_nxt = run ? ST_FETCH : ST_IDLE;
          end
          default: state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (class_q == CL_BEQ) begin
          pc_src    = PC_BRANCH;
          pc_write  = zero;
          retire    = 1'b1;
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end else if (class_q == CL_LW || class_q == CL_SW) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        bus.dmem_req       = 1'b1;
        ctrl_dataMem_Write = (class_q == CL_SW);
        if (bus.dmem_ready) begin
          if (class_q == CL_SW) begin
            retire    = 1'b1;
            state_nxt = run ? ST_FETCH : ST_IDLE;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (timeout_hit) begin
          state_nxt = ST_TRAP;
          err_nxt   = ERR_DMEM_TO;
        end
      end
      ST_WB: begin
        ctrl_regFile_write = 1'b1;
        select_regWritten  = (class_q == CL_ADD) || (class_q == CL_SUB);
        ctrl_dataMem2reg   = (class_q == CL_LW);
        retire             = 1'b1;
        state_nxt          = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: halted = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: one instruction per run pulse, bench-side
// memory responders with programmable wait, expected results from a small opcode model.
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          zero = 1'b0;
  logic          ir_load, pc_write, ctrl_regFile_write, select_regWritten;
  logic          ctrl_dataMem_Write, ctrl_dataMem2reg, select_anotherAluSource, halted;
  logic [1:0]    pc_src, select_aluPerformance, err_code;
  logic [RW-1:0] retired_count;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .RET_W(RW)) dut (
    .clk                     (clk),
    .rst_n_sequencer         (rst_n),
    .run                     (run),
    .bus                     (bus),
    .zero                    (zero),
    .ir_load                 (ir_load),
    .pc_write                (pc_write),
    .pc_src                  (pc_src),
    .ctrl_regFile_write      (ctrl_regFile_write),
    .select_regWritten       (select_regWritten),
    .ctrl_dataMem_Write      (ctrl_dataMem_Write),
    .ctrl_dataMem2reg        (ctrl_dataMem2reg),
    .select_anotherAluSource (select_anotherAluSource),
    .select_aluPerformance   (select_aluPerformance),
    .halted                  (halted),
    .err_code                (err_code),
    .retired_count           (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int err; int ireq; int dreq; int wr; int selrd; int m2r; int dmw;
    int wb_alu; int ret_pcw; int ret_pcs; int cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [RW-1:0] model_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input int iw, input int dw, input logic z);
    exp_t e;
    logic [5:0] op, fn;
    bit rt, legal, mem, sw;
    e = '{default: 0};
    op = ins[31:26];
    fn = ins[5:0];
    rt = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22);
    legal = rt || (op inside {6'h02, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b});
    mem = (op == 6'h23) || (op == 6'h2b);
    sw = (op == 6'h2b);
    if (iw >= TO) begin
      e.err = 2; e.ireq = TO;
    end else begin
      e.ireq = iw + 1;
      if (!legal) e.err = 1;
      else if (mem && dw >= TO) begin
        e.err = 3; e.dreq = TO; e.dmw = sw ? TO : 0;
      end else begin
        e.dreq = mem ? dw + 1 : 0;
        e.dmw  = sw ? dw + 1 : 0;
        e.wr   = (rt || op == 6'h0d || op == 6'h0f || op == 6'h23) ? 1 : 0;
        e.selrd = rt ? 1 : 0;
        e.m2r  = (op == 6'h23) ? 1 : 0;
        case (op)
          6'h02:   begin e.lat = 2; e.ret_pcw = 1; e.ret_pcs = 2; end
          6'h04:   begin e.lat = 3; e.ret_pcw = int'(z); e.ret_pcs = 1; end
          6'h23:   e.lat = 5;
          default: e.lat = 4;
        endcase
        e.lat = e.lat + iw + (mem ? dw : 0);
        if (rt) e.wb_alu = (fn == 6'h22) ? 3'b010 : 3'b000;
        else if (op == 6'h0d) e.wb_alu = 3'b101;
        else if (op == 6'h0f) e.wb_alu = 3'b111;
        else e.wb_alu = 3'b100;
      end
    end
    return e;
  endfunction

  task automatic exec_instr(input string name, input logic [31:0] ins, input int iw,
                            input int dw, input logic z, input int drop);
    exp_t e;
    int cyc = 0, icnt = 0, dcnt = 0, wr = 0, selrd = 0, m2r = 0, dmw = 0, wb_alu = 0;
    logic done = 1'b0;
    logic [RW-1:0] prev;
    logic pcw_h[64];
    logic [1:0] pcs_h[64];
    e = model(ins, iw, dw, z);
    if (e.err == 0) model_cnt = model_cnt + 1'b1;
    e.cnt = int'(model_cnt);
    sb.push_back(e);
    @(negedge clk);
    run = 1'b1;
    zero = z;
    prev = retired_count;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (retired_count !== prev || err_code !== 2'b00) done = 1'b1;
      else begin
        run = (cyc < drop);
        if (bus.imem_req) icnt++;
        if (bus.dmem_req) dcnt++;
        bus.imem_ready = bus.imem_req && (icnt == iw + 1);
        bus.dmem_ready = bus.dmem_req && (dcnt == dw + 1);
        if (bus.imem_ready) bus.instruction = ins;
        #1;
        pcw_h[cyc] = pc_write;
        pcs_h[cyc] = pc_src;
        if (ctrl_regFile_write) begin
          wr++;
          wb_alu = int'({select_anotherAluSource, select_aluPerformance});
        end
        if (select_regWritten) selrd++;
        if (ctrl_dataMem2reg) m2r++;
        if (ctrl_dataMem_Write) dmw++;
      end
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instruction = '1;
    run = 1'b0;
    #1;
    chk({name, " sb_nonempty"}, sb.size(), 1);
    e = sb.pop_front();
    chk({name, " finished"}, done, 1);
    chk({name, " err_code"}, err_code, e.err);
    chk({name, " imem_req_cycles"}, icnt, e.ireq);
    chk({name, " dmem_req_cycles"}, dcnt, e.dreq);
    chk({name, " rf_write_cycles"}, wr, e.wr);
    chk({name, " sel_rd_cycles"}, selrd, e.selrd);
    chk({name, " mem2reg_cycles"}, m2r, e.m2r);
    chk({name, " dm_write_cycles"}, dmw, e.dmw);
    chk({name, " retired_count"}, retired_count, e.cnt);
    chk({name, " halted"}, halted, 1);
    if (e.err == 0) begin
      chk({name, " latency"}, cyc - 1, e.lat);
      chk({name, " retire_pc_write"}, pcw_h[cyc-1], e.ret_pcw);
      chk({name, " retire_pc_src"}, pcs_h[cyc-1], e.ret_pcs);
      if (e.wr != 0) chk({name, " wb_alu"}, wb_alu, e.wb_alu);
    end else begin
      repeat (3) begin
        @(negedge clk);
        run = ~run;
      end
      #1;
      chk({name, " trap_halted"}, halted, 1);
      chk({name, " trap_err_held"}, err_code, e.err);
      chk({name, " trap_no_fetch"}, bus.imem_req, 0);
      chk({name, " trap_count_held"}, retired_count, e.cnt);
      run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk({name, " reset_err"}, err_code, 0);
      chk({name, " reset_halted"}, halted, 1);
      chk({name, " reset_count"}, retired_count, 0);
      model_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    logic [RW-1:0] held;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instruction = '1;
    repeat (2) @(negedge clk);
    chk("reset halted", halted, 1);
    chk("reset err_code", err_code, 0);
    chk("reset retired", retired_count, 0);
    chk("reset strobes", {bus.imem_req, bus.dmem_req, ir_load, pc_write, ctrl_regFile_write,
                          ctrl_dataMem_Write, ctrl_dataMem2reg, pc_src, select_aluPerformance}, 0);
    rst_n = 1'b1;

    exec_instr("add",       32'h0022_1820, 0, 0, 1'b0, 1);
    exec_instr("sub_iw1",   32'h0022_1822, 1, 0, 1'b0, 1);
    exec_instr("ori",       32'h3422_0005, 0, 0, 1'b0, 1);
    exec_instr("lui",       32'h3C02_0012, 0, 0, 1'b0, 1);
    exec_instr("lw_dw3",    32'h8C22_0004, 0, 3, 1'b0, 1);
    exec_instr("sw_drop",   32'hAC22_0004, 0, 2, 1'b0, 5);
    exec_instr("beq_z1",    32'h1022_0003, 0, 0, 1'b1, 1);
    exec_instr("beq_z0",    32'h1022_0003, 0, 0, 1'b0, 1);
    exec_instr("j",         32'h0800_0010, 0, 0, 1'b0, 1);
    exec_instr("add_iw3",   32'h0022_1820, 3, 0, 1'b0, 1);
    for (int k = 0; k < 8; k++) exec_instr("j_wrap", 32'h0800_0004, 0, 0, 1'b0, 1);

    exec_instr("illegal_op", 32'hFC00_0000, 0, 0, 1'b0, 1);
    exec_instr("illegal_fn", 32'h0022_1821, 0, 0, 1'b0, 1);
    exec_instr("imem_to",    32'h0022_1820, 99, 0, 1'b0, 1);
    exec_instr("dmem_to_sw", 32'hAC22_0004, 0, 99, 1'b0, 1);
    exec_instr("lw_after",   32'h8C22_0004, 2, 0, 1'b0, 1);

    held = retired_count;
    @(negedge clk);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle ready ignored halted", halted, 1);
    chk("idle ready ignored count", retired_count, held);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("fetch imem_req", bus.imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst imem_req", bus.imem_req, 0);
    chk("async rst halted", halted, 1);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
